// File: rtl/tthbif_uart_rf.sv
// rtl/tthbif_uart_rf.sv - UART command responder and lane tap-select register file
//
// Purpose: decodes command bytes from the UART rx stream, performs register
// reads/writes on the per-lane tap-select config, scratch and ID registers,
// and returns one response byte per command on the UART tx side.
//
// Ports:
//   clk_i              in   1            clock
//   rst_ni             in   1            asynchronous active-low reset
//   en_i               in   1            block enable
//   rx_data_valid_i    in   1            single-cycle strobe, rx_data_i holds a byte
//   rx_data_i          in   8            received byte
//   tx_data_ready_i    in   1            UART tx accepts response when high with valid
//   tx_data_valid_o    out  1            response byte valid
//   tx_data_o          out  8            response byte
//   rx_comb_tap_sel_o  out  2*NUM_LANES  lane i at [2i+1:2i]
//   rx_flop_tap_sel_o  out  2*NUM_LANES  lane i at [2i+1:2i]
//   tx_comb_tap_sel_o  out  2*NUM_LANES  lane i at [2i+1:2i]
//   tx_flop_tap_sel_o  out  2*NUM_LANES  lane i at [2i+1:2i]

module tthbif_uart_rf #(
  parameter int NUM_LANES    = 1,
  parameter int TIMEOUT_CLKS = 1_000_000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   rx_data_valid_i,
  input  logic [7:0]             rx_data_i,
  input  logic                   tx_data_ready_i,
  output logic                   tx_data_valid_o,
  output logic [7:0]             tx_data_o,
  output logic [2*NUM_LANES-1:0] rx_comb_tap_sel_o,
  output logic [2*NUM_LANES-1:0] rx_flop_tap_sel_o,
  output logic [2*NUM_LANES-1:0] tx_comb_tap_sel_o,
  output logic [2*NUM_LANES-1:0] tx_flop_tap_sel_o
);

  localparam int         CW      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam logic [7:0] ID_VAL  = 8'h48;
  localparam logic [3:0] A_SCR   = 4'hE;
  localparam logic [3:0] A_ID    = 4'hF;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                      state, state_next;
  logic [CW-1:0]               cnt, cnt_next;
  logic [3:0]                  wr_addr, wr_addr_next;
  logic [7:0]                  resp, resp_next;
  logic                        wr_en;
  logic [NUM_LANES-1:0][7:0]   lane_cfg;
  logic [7:0]                  scratch;

  logic [3:0] addr;
  logic       addr_ok;
  logic       cmd_bad;
  logic [7:0] rd_val;

  assign addr = rx_data_i[3:0];

  // Command decode on the incoming byte; read data is sampled in the same cycle.
  always_comb begin
    rd_val  = 8'h00;
    addr_ok = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (int'(addr) == i) begin
        rd_val  = lane_cfg[i];
        addr_ok = 1'b1;
      end
    end
    if (addr == A_SCR) begin
      rd_val  = scratch;
      addr_ok = 1'b1;
    end
    if (addr == A_ID) begin
      rd_val  = ID_VAL;
      addr_ok = !rx_data_i[7];   // ID is read-only
    end
    cmd_bad = (rx_data_i[6:4] != 3'b000) || !addr_ok;
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    wr_addr_next = wr_addr;
    resp_next    = resp;
    wr_en        = 1'b0;
    if (!en_i) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_data_valid_i) begin
            if (cmd_bad) begin
              // Invalid writes are rejected without waiting for a data byte.
              state_next = RESP;
              resp_next  = RSP_NAK;
            end else if (rx_data_i[7]) begin
              state_next   = DATA;
              cnt_next     = '0;
              wr_addr_next = addr;
            end else begin
              state_next = RESP;
              resp_next  = rd_val;
            end
          end
        end
        DATA: begin
          if (rx_data_valid_i) begin
            wr_en      = 1'b1;
            state_next = RESP;
            resp_next  = RSP_ACK;
          end else if (cnt == CW'(TIMEOUT_CLKS - 1)) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        RESP: begin
          // Rx strobes here are dropped; only the UART accept moves us on.
          if (tx_data_ready_i) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_addr <= 4'h0;
      resp    <= 8'h00;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      wr_addr <= wr_addr_next;
      resp    <= resp_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_cfg <= '1;
      scratch  <= 8'h00;
    end else if (wr_en) begin
      if (wr_addr == A_SCR) begin
        scratch <= rx_data_i;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        if (int'(wr_addr) == i) begin
          lane_cfg[i] <= rx_data_i;
        end
      end
    end
  end

  assign tx_data_valid_o = (state == RESP);
  assign tx_data_o       = resp;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign rx_comb_tap_sel_o[2*g +: 2] = lane_cfg[g][7:6];
    assign rx_flop_tap_sel_o[2*g +: 2] = lane_cfg[g][5:4];
    assign tx_comb_tap_sel_o[2*g +: 2] = lane_cfg[g][3:2];
    assign tx_flop_tap_sel_o[2*g +: 2] = lane_cfg[g][1:0];
  end

endmodule

// File: tb/tb_tthbif_uart_rf.sv
// tb/tb_tthbif_uart_rf.sv - self-checking bench for tthbif_uart_rf

module tb_tthbif_uart_rf;

  localparam int NL = 1;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            en;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            tx_ready;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic [2*NL-1:0] rx_comb, rx_flop, tx_comb, tx_flop;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_lane [NL];
  logic [7:0] m_scratch;

  tthbif_uart_rf #(.NUM_LANES(NL), .TIMEOUT_CLKS(TO)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .en_i              (en),
    .rx_data_valid_i   (rx_valid),
    .rx_data_i         (rx_data),
    .tx_data_ready_i   (tx_ready),
    .tx_data_valid_o   (tx_valid),
    .tx_data_o         (tx_data),
    .rx_comb_tap_sel_o (rx_comb),
    .rx_flop_tap_sel_o (rx_flop),
    .tx_comb_tap_sel_o (tx_comb),
    .tx_flop_tap_sel_o (tx_flop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_lane[i] = 8'hFF;
    m_scratch = 8'h00;
  endtask

  function automatic bit m_valid(input logic [7:0] c);
    int a;
    a = int'(c[3:0]);
    if (c[6:4] != 3'b000) return 0;
    if (a < NL) return 1;
    if (a == 14) return 1;
    if (a == 15) return !c[7];
    return 0;
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] a);
    if (int'(a) < NL) return m_lane[int'(a)];
    if (a == 4'hE) return m_scratch;
    return 8'h48;
  endfunction

  task automatic m_write(input logic [3:0] a, input logic [7:0] d);
    if (int'(a) < NL) m_lane[int'(a)] = d;
    else if (a == 4'hE) m_scratch = d;
  endtask

  task automatic chk_taps(input string tag);
    logic [2*NL-1:0] e_rc, e_rf, e_tc, e_tf;
    for (int i = 0; i < NL; i++) begin
      e_rc[2*i +: 2] = m_lane[i][7:6];
      e_rf[2*i +: 2] = m_lane[i][5:4];
      e_tc[2*i +: 2] = m_lane[i][3:2];
      e_tf[2*i +: 2] = m_lane[i][1:0];
    end
    chk({tag, "_rx_comb"}, 32'(rx_comb), 32'(e_rc));
    chk({tag, "_rx_flop"}, 32'(rx_flop), 32'(e_rf));
    chk({tag, "_tx_comb"}, 32'(tx_comb), 32'(e_tc));
    chk({tag, "_tx_flop"}, 32'(tx_flop), 32'(e_tf));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Called at the negedge after the final strobe: response must already be valid.
  task automatic expect_resp(input string tag, input logic [7:0] exp);
    int stall;
    chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
    chk({tag, "_data"}, 32'(tx_data), 32'(exp));
    stall = $urandom_range(0, 3);
    repeat (stall) begin
      @(negedge clk);
      chk({tag, "_hold"}, 32'(tx_data), 32'(exp));
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk({tag, "_drop"}, 32'(tx_valid), 32'd0);
  endtask

  task automatic do_cmd(input string tag, input logic [7:0] cmd, input logic [7:0] data, input int gap);
    logic [7:0] rv;
    rv = m_read(cmd[3:0]);
    send_byte(cmd);
    if (!m_valid(cmd)) begin
      expect_resp(tag, 8'h15);
    end else if (cmd[7]) begin
      chk({tag, "_nowait"}, 32'(tx_valid), 32'd0);
      repeat (gap) @(negedge clk);
      send_byte(data);
      m_write(cmd[3:0], data);
      expect_resp(tag, 8'h06);
    end else begin
      expect_resp(tag, rv);
    end
    chk_taps(tag);
  endtask

  initial begin
    logic [7:0] c;
    logic [3:0] a;
    int         r;

    rst_ni   = 1'b0;
    en       = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'h00);
    chk_taps("rst");
    rst_ni = 1'b1;

    // Basic reads, write, readback
    do_cmd("rd_id", 8'h0F, 8'h00, 0);
    do_cmd("rd_lane0", 8'h00, 8'h00, 0);
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    tx_ready = 1'b0;
    chk("ready_idle", 32'(tx_valid), 32'd0);
    do_cmd("wr_lane0", 8'h80, 8'h1B, 0);
    chk("lane0_rc", 32'(rx_comb[1:0]), 32'h0);
    chk("lane0_rf", 32'(rx_flop[1:0]), 32'h1);
    chk("lane0_tc", 32'(tx_comb[1:0]), 32'h2);
    chk("lane0_tf", 32'(tx_flop[1:0]), 32'h3);
    do_cmd("rb_lane0", 8'h00, 8'h00, 0);

    // Invalid commands
    do_cmd("rd_bad_addr", 8'h05, 8'h00, 0);
    do_cmd("rd_bad_bits", 8'h10, 8'h00, 0);
    do_cmd("wr_id", 8'h8F, 8'h00, 0);
    do_cmd("after_wr_id", 8'h0E, 8'h00, 0);

    // Timeout: data never arrives
    send_byte(8'h8E);
    repeat (TO) begin
      @(negedge clk);
      chk("to_novalid", 32'(tx_valid), 32'd0);
    end
    do_cmd("to_rd_scr", 8'h0E, 8'h00, 0);

    // Last clock before timeout is still accepted
    do_cmd("to_edge_ok", 8'h8E, 8'h77, TO - 2);
    do_cmd("to_edge_rb", 8'h0E, 8'h00, 0);
    // One clock later the byte is decoded as a new command
    send_byte(8'h8E);
    repeat (TO - 1) @(negedge clk);
    chk("to_late_nowait", 32'(tx_valid), 32'd0);
    send_byte(8'h0E);
    expect_resp("to_late_as_cmd", m_scratch);

    // Stall in RESP with extra rx strobes
    send_byte(8'h0F);
    for (int i = 0; i < 20; i++) begin
      rx_valid = (i % 2 == 0) && (i < 19);
      rx_data  = (i % 4 == 0) ? 8'h8E : 8'h80;
      @(negedge clk);
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_data", 32'(tx_data), 32'h48);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("stall_drop", 32'(tx_valid), 32'd0);
    do_cmd("stall_scr", 8'h0E, 8'h00, 0);
    do_cmd("stall_lane", 8'h00, 8'h00, 0);

    // Enable drop during DATA
    send_byte(8'h8E);
    en       = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    @(negedge clk);
    en       = 1'b1;
    rx_valid = 1'b0;
    chk("en_data_novalid", 32'(tx_valid), 32'd0);
    do_cmd("en_data_scr", 8'h0E, 8'h00, 0);

    // Enable drop during RESP
    send_byte(8'h0F);
    chk("en_resp_valid", 32'(tx_valid), 32'd1);
    en = 1'b0;
    @(negedge clk);
    chk("en_resp_drop", 32'(tx_valid), 32'd0);
    en = 1'b1;
    @(negedge clk);
    chk("en_resp_idle", 32'(tx_valid), 32'd0);
    chk_taps("en_resp");

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: c = 8'($urandom);
        1: begin a = ($urandom_range(0, 2) == 0) ? 4'hE : (($urandom_range(0, 1) == 0) ? 4'hF : 4'(NL - 1)); c = {4'h0, a}; end
        2: begin a = ($urandom_range(0, 1) == 0) ? 4'hE : 4'(NL - 1); c = {4'h8, a}; end
        default: c = {1'($urandom), 3'b000, 4'($urandom)};
      endcase
      do_cmd($sformatf("rnd%0d", n), c, 8'($urandom), $urandom_range(0, 4));
    end

    // Async reset mid-RESP
    do_cmd("pre_rst_lane", 8'h80, 8'hA5, 1);
    do_cmd("pre_rst_scr", 8'h8E, 8'h3C, 0);
    send_byte(8'h0E);
    chk("pre_rst_valid", 32'(tx_valid), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(tx_valid), 32'd0);
    chk("arst_data", 32'(tx_data), 32'h00);
    chk_taps("arst");
    @(negedge clk);
    rst_ni = 1'b1;
    do_cmd("post_rst_scr", 8'h0E, 8'h00, 0);
    do_cmd("post_rst_lane", 8'h00, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
